// File: rtl/nco_ddc_mixer.sv
// Quadrature downconversion mixer: I = round(adc*cos), Q = round(-adc*sin), saturated to ow bits.
// Latency: 3 enabled clocks from input capture to output register.
// No backpressure: always ready; every stage advances only when clken=1 (ovf_clr acts regardless).
module nco_ddc_mixer #(
    parameter int adw = 16,
    parameter int mpr = 17,
    parameter int ow  = 24,
    parameter int sh  = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clken,
    input  logic [adw-1:0] adc_data,
    input  logic           adc_valid,
    input  logic [mpr-1:0] nco_sin,
    input  logic [mpr-1:0] nco_cos,
    input  logic           nco_valid,
    input  logic           ovf_clr,
    output logic [ow-1:0]  mix_i,
    output logic [ow-1:0]  mix_q,
    output logic           mix_valid,
    output logic           ovf
);

    // Products are held one bit wider than adw+mpr so the Q negation of
    // (-2^(adw-1)) * (-2^(mpr-1)) cannot wrap.
    localparam int PW = adw + mpr + 1;

    // Rounding constant and saturation limits, sized to the pre-shift sum.
    localparam logic signed [PW:0] RND  = (PW+1)'(2**(sh-1));
    localparam logic signed [PW:0] MAXV = (PW+1)'(2**(ow-1) - 1);
    localparam logic signed [PW:0] MINV = -((PW+1)'(2**(ow-1)));

    // Stage 1 registers
    logic signed [adw-1:0] adc_q;
    logic signed [mpr-1:0] sin_q, cos_q;
    logic                  v1_q;

    // Stage 2 registers
    logic signed [PW-1:0]  pi_q, pq_q;
    logic                  v2_q;

    // Stage 3 / output registers
    logic signed [ow-1:0]  mix_i_q, mix_q_q;
    logic                  mix_valid_q, ovf_q;

    // Next-state signals
    logic signed [PW-1:0]  adc_x, cos_x, sin_x;
    logic signed [PW-1:0]  pi_d, pq_d;
    logic [ow:0]           res_i, res_q;
    logic                  sat_any;
    logic                  ovf_d;

    // Round half toward +inf, arithmetic shift, then clamp; bit ow flags a clamp.
    function automatic logic [ow:0] rnd_sat(input logic signed [PW-1:0] p);
        logic signed [PW:0] sum;
        logic signed [PW:0] r;
        logic [ow:0]        res;
        sum = {p[PW-1], p} + RND;
        r   = sum >>> sh;
        if (r > MAXV) begin
            res = {1'b1, MAXV[ow-1:0]};
        end else if (r < MINV) begin
            res = {1'b1, MINV[ow-1:0]};
        end else begin
            res = {1'b0, r[ow-1:0]};
        end
        return res;
    endfunction

    // Stage 2 products: sign-extend operands so the multiply is done at full width.
    always_comb begin
        adc_x = {{(PW-adw){adc_q[adw-1]}}, adc_q};
        cos_x = {{(PW-mpr){cos_q[mpr-1]}}, cos_q};
        sin_x = {{(PW-mpr){sin_q[mpr-1]}}, sin_q};
        pi_d  = adc_x * cos_x;
        pq_d  = -(adc_x * sin_x);
    end

    // Stage 3 rounding/saturation and the sticky flag's next state; a new
    // valid saturation on an enabled edge beats a coincident clear.
    always_comb begin
        res_i   = rnd_sat(pi_q);
        res_q   = rnd_sat(pq_q);
        sat_any = v2_q & (res_i[ow] | res_q[ow]);
        ovf_d   = (clken & sat_any) | (ovf_q & ~ovf_clr);
    end

    // Three-stage pipeline, advancing only on enabled edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adc_q       <= '0;
            sin_q       <= '0;
            cos_q       <= '0;
            v1_q        <= 1'b0;
            pi_q        <= '0;
            pq_q        <= '0;
            v2_q        <= 1'b0;
            mix_i_q     <= '0;
            mix_q_q     <= '0;
            mix_valid_q <= 1'b0;
        end else if (clken) begin
            adc_q       <= adc_data;
            sin_q       <= nco_sin;
            cos_q       <= nco_cos;
            v1_q        <= adc_valid & nco_valid;
            pi_q        <= pi_d;
            pq_q        <= pq_d;
            v2_q        <= v1_q;
            mix_i_q     <= res_i[ow-1:0];
            mix_q_q     <= res_q[ow-1:0];
            mix_valid_q <= v2_q;
        end
    end

    // Sticky overflow flag; updates every edge so ovf_clr works while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign mix_i     = mix_i_q;
    assign mix_q     = mix_q_q;
    assign mix_valid = mix_valid_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_nco_ddc_mixer.sv
module tb_nco_ddc_mixer;

    logic               clk = 1'b0;
    logic               reset;
    logic               clken;
    logic signed [15:0] adc_data;
    logic               adc_valid;
    logic signed [16:0] nco_sin;
    logic signed [16:0] nco_cos;
    logic               nco_valid;
    logic               ovf_clr;
    logic signed [23:0] mix_i;
    logic signed [23:0] mix_q;
    logic               mix_valid;
    logic               ovf;

    int checks = 0;
    int errors = 0;

    nco_ddc_mixer dut (
        .clk       (clk),
        .reset     (reset),
        .clken     (clken),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .nco_sin   (nco_sin),
        .nco_cos   (nco_cos),
        .nco_valid (nco_valid),
        .ovf_clr   (ovf_clr),
        .mix_i     (mix_i),
        .mix_q     (mix_q),
        .mix_valid (mix_valid),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string   name;
        int      adc;
        int      sn;
        int      cs;
        longint  exp_i;
        longint  exp_q;
        logic    exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input int a, input int s, input int c);
        adc_data = 16'(a);
        nco_sin  = 17'(s);
        nco_cos  = 17'(c);
    endtask

    int samp[8]   = '{1000, -2000, 3000, 777, 0, 0, 0, 0};
    bit samp_v[8] = '{1, 0, 1, 1, 1, 1, 1, 1};
    bit pat[12]   = '{1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 1, 1};

    initial begin
        vecs[0] = '{"dc_tone",      16384,     0, 65535,  4194240,        0, 1'b0};
        vecs[1] = '{"dc_neg",      -16384,     0, 65535, -4194240,        0, 1'b0};
        vecs[2] = '{"sin_only",     16384, 65535,     0,        0, -4194240, 1'b0};
        vecs[3] = '{"rnd_i_128",        1,     0,   128,        1,        0, 1'b0};
        vecs[4] = '{"rnd_i_127",        1,     0,   127,        0,        0, 1'b0};
        vecs[5] = '{"rnd_i_neg",       -1,     0,   128,        0,        0, 1'b0};
        vecs[6] = '{"rnd_q_128",        1,   128,     0,        0,        0, 1'b0};
        vecs[7] = '{"rnd_q_neg",       -1,   128,    -384,       1,        1, 1'b0};
        // vecs[7]: I = -1*-384 = 384 -> (384+128)>>8 = 2? recomputed below
        vecs[7].exp_i = 2;   // (384+128)/256 = 2
        vecs[7].exp_q = 1;   // -(-128)=128 -> (128+128)/256 = 1

        reset = 1'b1; clken = 1'b0; adc_valid = 1'b0; nco_valid = 1'b0; ovf_clr = 1'b0;
        drive(0, 0, 0);
        #3;
        chk("reset_i", mix_i, 0);
        chk("reset_q", mix_q, 0);
        chk("reset_valid", mix_valid, 0);
        chk("reset_ovf", ovf, 0);
        step();
        reset = 1'b0;

        // Table-driven steady-state vectors
        clken = 1'b1; adc_valid = 1'b1; nco_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(vecs[k].adc, vecs[k].sn, vecs[k].cs);
            repeat (3) step();
            chk({vecs[k].name, "_i"}, mix_i, vecs[k].exp_i);
            chk({vecs[k].name, "_q"}, mix_q, vecs[k].exp_q);
            chk({vecs[k].name, "_valid"}, mix_valid, 1);
            chk({vecs[k].name, "_ovf"}, ovf, vecs[k].exp_ovf);
        end

        // Saturation corner
        drive(-32768, -65536, -65536);
        repeat (3) step();
        chk("sat_i", mix_i, 8388607);
        chk("sat_q", mix_q, -8388608);
        chk("sat_ovf", ovf, 1);
        drive(0, 0, 0);
        repeat (3) step();
        chk("sat_sticky", ovf, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", ovf, 0);
        // Saturate again, then clear while stalled
        drive(-32768, -65536, -65536);
        repeat (3) step();
        chk("sat_again", ovf, 1);
        clken = 1'b0; ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr_stalled", ovf, 0);
        clken = 1'b1;
        // Pipeline still full of saturating samples: next edge sets while clear requested
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("set_beats_clr", ovf, 1);
        drive(0, 0, 0);
        repeat (3) step();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr2", ovf, 0);

        // Valid gating: saturating data with nco_valid low
        nco_valid = 1'b0;
        drive(-32768, -65536, -65536);
        repeat (3) step();
        chk("gate_valid", mix_valid, 0);
        chk("gate_ovf", ovf, 0);
        drive(0, 0, 0);
        nco_valid = 1'b1;
        step();
        chk("nv_rise_1", mix_valid, 0);
        step();
        chk("nv_rise_2", mix_valid, 0);
        step();
        chk("nv_rise_3", mix_valid, 1);
        chk("gate_ovf_after", ovf, 0);

        // clken stall: flush with zeros at cos=256 so I equals adc
        drive(0, 0, 256);
        repeat (3) step();
        begin
            int     n;
            longint exp_i;
            logic   exp_v;
            n = 0; exp_i = 0; exp_v = 1'b1;
            for (int c = 0; c < 12; c++) begin
                clken     = pat[c];
                adc_data  = 16'(samp[n]);
                adc_valid = samp_v[n];
                step();
                if (pat[c]) begin
                    n++;
                    if (n >= 3) begin
                        exp_i = samp[n-3];
                        exp_v = samp_v[n-3];
                    end
                end
                chk($sformatf("stall_i_%0d", c), mix_i, exp_i);
                chk($sformatf("stall_v_%0d", c), mix_valid, exp_v);
            end
        end
        clken = 1'b1; adc_valid = 1'b1;

        // Reset mid-stream with valid data and ovf set
        drive(-32768, -65536, -65536);
        repeat (3) step();
        chk("pre_reset_ovf", ovf, 1);
        drive(16384, 0, 65535);
        step();
        reset = 1'b1;
        #1;
        chk("midrst_i", mix_i, 0);
        chk("midrst_q", mix_q, 0);
        chk("midrst_valid", mix_valid, 0);
        chk("midrst_ovf", ovf, 0);
        #2;
        reset = 1'b0;
        step();
        chk("post_rst_1", mix_valid, 0);
        step();
        chk("post_rst_2", mix_valid, 0);
        step();
        chk("post_rst_3", mix_valid, 1);
        chk("post_rst_i", mix_i, 4194240);
        chk("post_rst_ovf", ovf, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nco_ddc_mixer.md
Name: nco_ddc_mixer

Overview:
- Quadrature downconversion mixer that consumes the NCO's sine/cosine outputs and their valid flag.
- Multiplies each ADC sample by cos and by -sin to produce baseband I/Q.
- Rounds and saturates I/Q to the output width; a sticky flag records any saturation.
- Sits directly downstream of the NCO, upstream of the decimating filter chain; shares the NCO's clk and clken.

Parameters:
- adw, 16, ADC sample width (signed two's complement)
- mpr, 17, NCO sin/cos width (signed), matches NCO magnitude precision
- ow, 24, output I/Q width (signed)
- sh, 8, right-shift applied to the full product before rounding; must satisfy sh = adw+mpr-1-ow

Ports:
- clk, input, 1, system clock
- reset, input, 1, asynchronous active-high reset
- clken, input, 1, global clock enable; all registers advance only when 1
- adc_data, input, adw, signed ADC sample
- adc_valid, input, 1, adc_data valid this cycle
- nco_sin, input, mpr, signed NCO sine (fsin_o)
- nco_cos, input, mpr, signed NCO cosine (fcos_o)
- nco_valid, input, 1, NCO out_valid
- ovf_clr, input, 1, synchronous clear of the sticky overflow flag (acts regardless of clken)
- mix_i, output, ow, signed in-phase result
- mix_q, output, ow, signed quadrature result
- mix_valid, output, 1, mix_i/mix_q valid
- ovf, output, 1, sticky saturation flag

Behaviour:
- Reset is asynchronous and active-high. On assertion, all pipeline registers clear: mix_i=0, mix_q=0, mix_valid=0, ovf=0. This applies mid-operation too: in-flight samples are discarded, and mix_valid stays 0 until new data propagates through.
- Pipeline is three stages, each updating only on clk edges with clken=1:
  - S1: register adc_data, nco_sin, nco_cos, and v1 = adc_valid & nco_valid.
  - S2: pi = adc*cos as a full (adw+mpr)-bit signed product. pq = -(adc*sin), computed in adw+mpr+1 bits so the negation cannot overflow. v2 = v1.
  - S3: for each of pi/pq, r = (p + 2^(sh-1)) >>> sh (arithmetic shift; round half toward +inf). Saturate r to [-2^(ow-1), 2^(ow-1)-1]. Register results to mix_i/mix_q; mix_valid = v2.
- Latency: an input sampled on enabled edge k appears on outputs after enabled edge k+2, i.e. 3 enabled clocks from input to output register.
- With clken=0, all registers and outputs hold, and mix_valid holds its value. Downstream must qualify with clken & mix_valid.
- Invalid samples (v=0) still flow through the datapath. Outputs update with whatever is computed, but mix_valid=0 for them.
- ovf:
  - Set at the S3 register update when either channel saturates, but only if v2=1.
  - Stays set until reset or ovf_clr.
  - ovf_clr=1 clears ovf on the next clk edge independent of clken.
  - If ovf_clr and a new saturation occur in the same cycle, set wins (ovf=1).
- Only the I product can saturate, and only for adc=-2^(adw-1) with cos=-2^(mpr-1). The Q path with the equivalent inputs yields exactly -2^(ow-1), which does not saturate.
- Startup: mix_valid stays 0 until the NCO asserts nco_valid and that flag has propagated 3 enabled clocks.
- There is no backpressure; the block is always ready.

Test Plan:
- Reset: assert reset mid-stream with v=1 data in flight → mix_i=0, mix_q=0, mix_valid=0, ovf=0 immediately (asynchronous); first valid output appears 3 enabled clocks after inputs resume.
- DC tone: adc=16384, cos=65535, sin=0, both valids=1, clken=1 → after 3 clocks mix_i=4194240, mix_q=0, mix_valid=1, ovf=0.
- Saturation corner: adc=-32768, cos=-65536, sin=-65536 → mix_i=8388607 (saturated), mix_q=-8388608, ovf=1. Then ovf_clr pulse → ovf=0 next edge. ovf_clr coincident with another saturating valid sample → ovf stays 1.
- Rounding: adc=1, cos=128 → mix_i=1; adc=1, cos=127 → mix_i=0; adc=-1, cos=128 → mix_i=0; adc=1, sin=128 → mix_q=0 (the rounded value of -128/256 is 0).
- clken stall: stream 4 samples with clken toggling 1,0,0,1,...; outputs and mix_valid hold during clken=0, and each sample emerges exactly 3 enabled edges after capture, in order.
- Valid gating: nco_valid=0 while adc_valid=1 → mix_valid=0 and no ovf even with saturating data; mix_valid rises 3 enabled clocks after nco_valid rises.
